// File: rtl/mem_loader.sv
// mem_loader: framed byte-stream program loader for the 64 KiB system memory.
// Accepts SYNC / ADDR / LEN / data / CHK frames, writes the data bytes into
// memory, optionally reads them back to confirm the sum, and holds the CPU in
// reset until a good image is resident.
module mem_loader #(
   parameter logic [7:0] SYNC_BYTE = 8'h55,
   parameter bit         VERIFY    = 1'b1
) (
   input  logic        CLK,
   input  logic        RESET_N,
   input  logic [7:0]  RxData,
   input  logic        RxValid,
   output logic        RxReady,
   output logic        MemWE,
   output logic [15:0] MemAddress,
   output logic [7:0]  MemDataIn,
   input  logic [7:0]  MemDataOut,
   output logic        CpuHold,
   output logic        Busy,
   output logic        Done,
   output logic        Error,
   output logic [7:0]  Checksum
);

   typedef enum logic [2:0] {
      S_IDLE, S_HDR, S_DATA, S_CHK, S_VERIFY, S_DONE, S_ERROR
   } state_t;

   state_t      state_q, state_nxt;

   logic        accept;
   logic        is_sync;
   logic [1:0]  hdr_cnt;
   logic [15:0] remain;
   logic [15:0] vcnt;
   logic        vld_p0;
   logic        vld_p1;

   logic [15:0] start_addr;
   logic [15:0] len;
   logic [15:0] ptr;
   logic [7:0]  sum;
   logic [7:0]  vsum;
   logic [7:0]  chk_total;
   logic [7:0]  vsum_final;
   logic [15:0] hdr_len;

   logic        busy_nxt, done_nxt, error_nxt, hold_nxt;

   assign accept     = RxValid & RxReady;
   assign is_sync    = (RxData == SYNC_BYTE);
   assign hdr_len    = {RxData, len[7:0]};
   assign chk_total  = sum + RxData;
   // Readback stage: an address issued this cycle returns data next cycle.
   assign vld_p0     = (vcnt < len);
   assign vsum_final = vsum + (vld_p1 ? MemDataOut : 8'd0);

   // State register.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) state_q <= S_IDLE;
      else          state_q <= state_nxt;
   end

   // Next-state decode.
   always_comb begin
      state_nxt = state_q;
      case (state_q)
         S_IDLE:   if (accept && is_sync) state_nxt = S_HDR;
         S_HDR:    if (accept && hdr_cnt == 2'd3)
                      state_nxt = (hdr_len == 16'd0) ? S_CHK : S_DATA;
         S_DATA:   if (accept && remain == 16'd1) state_nxt = S_CHK;
         S_CHK:    if (accept) begin
                      if (chk_total != 8'd0) state_nxt = S_ERROR;
                      else if (VERIFY)      state_nxt = S_VERIFY;
                      else                  state_nxt = S_DONE;
                   end
         S_VERIFY: if (vcnt == len)
                      state_nxt = (vsum_final == sum) ? S_DONE : S_ERROR;
         S_DONE:   if (accept && is_sync) state_nxt = S_HDR;
         S_ERROR:  state_nxt = S_ERROR;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Output decode: RxReady from the current state, status flags from the next.
   always_comb begin
      RxReady   = 1'b0;
      busy_nxt  = 1'b0;
      done_nxt  = 1'b0;
      error_nxt = 1'b0;
      hold_nxt  = 1'b1;
      case (state_q)
         S_IDLE, S_HDR, S_DATA, S_CHK, S_DONE: RxReady = 1'b1;
         default:                              RxReady = 1'b0;
      endcase
      case (state_nxt)
         S_HDR, S_DATA, S_CHK, S_VERIFY: busy_nxt = 1'b1;
         S_DONE:  begin done_nxt = 1'b1; hold_nxt = 1'b0; end
         S_ERROR: error_nxt = 1'b1;
         default: ;
      endcase
   end

   // Control counters: header byte index, data bytes remaining, verify progress.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         hdr_cnt <= 2'd0;
         remain  <= 16'd0;
         vcnt    <= 16'd0;
         vld_p1  <= 1'b0;
      end else begin
         if ((state_q == S_IDLE || state_q == S_DONE) && accept && is_sync)
            hdr_cnt <= 2'd0;
         else if (state_q == S_HDR && accept)
            hdr_cnt <= hdr_cnt + 2'd1;

         if (state_q == S_HDR && accept && hdr_cnt == 2'd3)
            remain <= hdr_len;
         else if (state_q == S_DATA && accept)
            remain <= remain - 16'd1;

         if (state_q == S_CHK && accept)
            vcnt <= 16'd0;
         else if (state_q == S_VERIFY)
            vcnt <= vcnt + 16'd1;

         vld_p1 <= (state_q == S_VERIFY) ? vld_p0 : 1'b0;
      end
   end

   // Datapath registers; each is loaded before it is consumed, so no reset.
   always_ff @(posedge CLK) begin
      if ((state_q == S_IDLE || state_q == S_DONE) && accept && is_sync)
         sum <= 8'd0;
      else if (state_q == S_DATA && accept)
         sum <= sum + RxData;

      if (state_q == S_HDR && accept) begin
         case (hdr_cnt)
            2'd0: start_addr[7:0]  <= RxData;
            2'd1: begin
               start_addr[15:8] <= RxData;
               ptr              <= {RxData, start_addr[7:0]};
            end
            2'd2: len[7:0]         <= RxData;
            default: len[15:8]     <= RxData;
         endcase
      end else if (state_q == S_DATA && accept) begin
         ptr <= ptr + 16'd1;
      end

      if (state_q == S_CHK && accept)
         vsum <= 8'd0;
      else if (state_q == S_VERIFY && vld_p1)
         vsum <= vsum + MemDataOut;
   end

   // Registered outputs: memory port and status flags.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         MemWE      <= 1'b0;
         MemAddress <= 16'd0;
         MemDataIn  <= 8'd0;
         Checksum   <= 8'd0;
         CpuHold    <= 1'b1;
         Busy       <= 1'b0;
         Done       <= 1'b0;
         Error      <= 1'b0;
      end else begin
         MemWE <= (state_q == S_DATA) && accept;
         if (state_q == S_DATA && accept) begin
            MemAddress <= ptr;
            MemDataIn  <= RxData;
         end else if (state_q == S_CHK && accept) begin
            MemAddress <= start_addr;
         end else if (state_q == S_VERIFY) begin
            MemAddress <= MemAddress + 16'd1;
         end
         if (state_q == S_CHK && accept)
            Checksum <= sum;
         CpuHold <= hold_nxt;
         Busy    <= busy_nxt;
         Done    <= done_nxt;
         Error   <= error_nxt;
      end
   end

endmodule

// File: tb/tb_mem_loader.sv
// Bench for mem_loader: behavioural 64 KiB memory, expected-write scoreboard,
// directed frame sequences.
module tb_mem_loader;

   logic        CLK = 1'b0;
   logic        RESET_N;
   logic [7:0]  RxData;
   logic        RxValid;
   logic        RxReady;
   logic        MemWE;
   logic [15:0] MemAddress;
   logic [7:0]  MemDataIn;
   logic [7:0]  MemDataOut;
   logic        CpuHold;
   logic        Busy;
   logic        Done;
   logic        Error;
   logic [7:0]  Checksum;

   logic [7:0]  mem [0:65535];
   logic        corrupt_en;
   logic [15:0] corrupt_addr;

   typedef struct packed {
      logic [15:0] a;
      logic [7:0]  d;
   } wr_t;

   wr_t        exp_q[$];
   logic [7:0] frame[$];
   int         vectors    = 0;
   int         miscompares = 0;
   int         cyc;

   always #5 CLK = ~CLK;

   mem_loader #(.SYNC_BYTE(8'h55), .VERIFY(1'b1)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .RxData(RxData), .RxValid(RxValid),
      .RxReady(RxReady), .MemWE(MemWE), .MemAddress(MemAddress),
      .MemDataIn(MemDataIn), .MemDataOut(MemDataOut), .CpuHold(CpuHold),
      .Busy(Busy), .Done(Done), .Error(Error), .Checksum(Checksum)
   );

   // Synchronous memory with registered read and optional readback corruption.
   always @(posedge CLK) begin
      if (MemWE) mem[MemAddress] <= MemDataIn;
      if (corrupt_en && MemAddress == corrupt_addr)
         MemDataOut <= mem[MemAddress] ^ 8'hFF;
      else
         MemDataOut <= mem[MemAddress];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock; then any write strobe must match the head of the scoreboard.
   task automatic tick();
      wr_t w;
      @(posedge CLK);
      #1;
      if (MemWE === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_we", {31'd0, MemWE}, 32'd0);
         end else begin
            w = exp_q.pop_front();
            check("wr_addr", {16'd0, MemAddress}, {16'd0, w.a});
            check("wr_data", {24'd0, MemDataIn}, {24'd0, w.d});
         end
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      check("rxready", {31'd0, RxReady}, 32'd1);
      RxData  = b;
      RxValid = 1'b1;
      tick();
      RxValid = 1'b0;
   endtask

   // Sends the bytes in frame; data bytes are queued as expected writes.
   task automatic send_frame(input bit gaps, input bit chk_hold);
      int          len;
      logic [15:0] base;
      logic [15:0] a;
      wr_t         w;
      len  = {frame[4], frame[3]};
      base = {frame[2], frame[1]};
      for (int i = 0; i < frame.size(); i++) begin
         if (i >= 5 && i < 5 + len) begin
            a   = base + 16'(i - 5);
            w.a = a;
            w.d = frame[i];
            exp_q.push_back(w);
         end
         send_byte(frame[i]);
         if (i == 0 && chk_hold) begin
            check("resync_hold", {31'd0, CpuHold}, 32'd1);
            check("resync_done", {31'd0, Done}, 32'd0);
         end
         if (gaps) tick();
      end
   endtask

   task automatic wait_end(output int n);
      n = 0;
      while (!(Done || Error) && n < 200) begin
         tick();
         n++;
      end
      if (!(Done || Error)) check("end_timeout", {31'd0, Done | Error}, 32'd1);
      check("wr_queue_empty", exp_q.size(), 32'd0);
   endtask

   task automatic do_reset();
      RESET_N    = 1'b0;
      RxValid    = 1'b0;
      corrupt_en = 1'b0;
      exp_q.delete();
      tick();
      tick();
      check("rst_we",    {31'd0, MemWE}, 32'd0);
      check("rst_addr",  {16'd0, MemAddress}, 32'd0);
      check("rst_din",   {24'd0, MemDataIn}, 32'd0);
      check("rst_hold",  {31'd0, CpuHold}, 32'd1);
      check("rst_busy",  {31'd0, Busy}, 32'd0);
      check("rst_done",  {31'd0, Done}, 32'd0);
      check("rst_error", {31'd0, Error}, 32'd0);
      check("rst_chk",   {24'd0, Checksum}, 32'd0);
      check("rst_ready", {31'd0, RxReady}, 32'd1);
      RESET_N = 1'b1;
   endtask

   task automatic load_basic(input logic [7:0] chk);
      frame = '{8'h55, 8'h00, 8'h03, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33, chk};
   endtask

   initial begin
      RESET_N      = 1'b0;
      RxValid      = 1'b0;
      RxData       = 8'h00;
      corrupt_en   = 1'b0;
      corrupt_addr = 16'h0301;

      // Basic load
      do_reset();
      load_basic(8'h9A);
      send_frame(1'b0, 1'b0);
      check("basic_busy", {31'd0, Busy}, 32'd1);
      wait_end(cyc);
      check("basic_verify_cycles", cyc, 32'd4);
      check("basic_done",  {31'd0, Done}, 32'd1);
      check("basic_hold",  {31'd0, CpuHold}, 32'd0);
      check("basic_chk",   {24'd0, Checksum}, 32'h66);
      check("basic_error", {31'd0, Error}, 32'd0);
      check("basic_busy_end", {31'd0, Busy}, 32'd0);
      check("mem_0300", {24'd0, mem[16'h0300]}, 32'h11);
      check("mem_0301", {24'd0, mem[16'h0301]}, 32'h22);
      check("mem_0302", {24'd0, mem[16'h0302]}, 32'h33);

      // Bad checksum
      do_reset();
      load_basic(8'h9B);
      send_frame(1'b0, 1'b0);
      wait_end(cyc);
      check("bad_error", {31'd0, Error}, 32'd1);
      check("bad_hold",  {31'd0, CpuHold}, 32'd1);
      check("bad_done",  {31'd0, Done}, 32'd0);
      check("bad_ready", {31'd0, RxReady}, 32'd0);
      for (int i = 0; i < 3; i++) tick();
      check("bad_sticky", {31'd0, Error}, 32'd1);
      check("bad_mem_0300", {24'd0, mem[16'h0300]}, 32'h11);
      check("bad_mem_0301", {24'd0, mem[16'h0301]}, 32'h22);
      check("bad_mem_0302", {24'd0, mem[16'h0302]}, 32'h33);

      // Address wrap with idle cycles between bytes
      do_reset();
      frame = '{8'h55, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'hAA, 8'hBB, 8'h9B};
      send_frame(1'b1, 1'b0);
      wait_end(cyc);
      check("wrap_done", {31'd0, Done}, 32'd1);
      check("wrap_chk",  {24'd0, Checksum}, 32'h65);
      check("wrap_mem_ffff", {24'd0, mem[16'hFFFF]}, 32'hAA);
      check("wrap_mem_0000", {24'd0, mem[16'h0000]}, 32'hBB);

      // Noise then zero-length frame, starting from DONE
      send_byte(8'h00);
      send_byte(8'h7F);
      check("noise_done", {31'd0, Done}, 32'd1);
      frame = '{8'h55, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00};
      send_frame(1'b0, 1'b1);
      wait_end(cyc);
      check("zero_verify_cycles", cyc, 32'd1);
      check("zero_done", {31'd0, Done}, 32'd1);
      check("zero_chk",  {24'd0, Checksum}, 32'h00);
      check("zero_hold", {31'd0, CpuHold}, 32'd0);

      // Readback corruption at 0x0301
      do_reset();
      corrupt_en = 1'b1;
      load_basic(8'h9A);
      send_frame(1'b0, 1'b0);
      wait_end(cyc);
      check("vfail_cycles", cyc, 32'd4);
      check("vfail_error", {31'd0, Error}, 32'd1);
      check("vfail_hold",  {31'd0, CpuHold}, 32'd1);
      check("vfail_done",  {31'd0, Done}, 32'd0);
      corrupt_en = 1'b0;

      // Reset after the second data byte, then two full loads
      do_reset();
      load_basic(8'h9A);
      for (int i = 0; i < 7; i++) begin
         if (i >= 5) exp_q.push_back({16'h0300 + 16'(i - 5), frame[i]});
         send_byte(frame[i]);
      end
      check("mid_busy", {31'd0, Busy}, 32'd1);
      RESET_N = 1'b0;
      #1;
      check("async_we",   {31'd0, MemWE}, 32'd0);
      check("async_hold", {31'd0, CpuHold}, 32'd1);
      check("async_busy", {31'd0, Busy}, 32'd0);
      check("async_wrq",  exp_q.size(), 32'd0);
      do_reset();
      load_basic(8'h9A);
      send_frame(1'b0, 1'b0);
      wait_end(cyc);
      check("reload1_done", {31'd0, Done}, 32'd1);
      check("reload1_hold", {31'd0, CpuHold}, 32'd0);
      load_basic(8'h9A);
      send_frame(1'b0, 1'b1);
      check("reload2_hold_busy", {31'd0, CpuHold}, 32'd1);
      wait_end(cyc);
      check("reload2_cycles", cyc, 32'd4);
      check("reload2_done", {31'd0, Done}, 32'd1);
      check("reload2_hold", {31'd0, CpuHold}, 32'd0);
      check("reload2_mem_0301", {24'd0, mem[16'h0301]}, 32'h22);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
